// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pulls bytes from the TX BRAM FIFO and shifts them out as 8N1
// UART frames on txd. Owns the FIFO read side. One wait cycle (FETCH) covers
// the BRAM read latency. fifo_empty is only looked at in IDLE, so the one-cycle
// lag of the FIFO empty flag can never cause a pop of an empty FIFO.
module uart_tx_drain #(
    parameter int CLK_PER_BIT = 868,
    parameter int DATAW       = 8,
    parameter int CNTW        = $clog2(CLK_PER_BIT)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [DATAW-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             txd,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLK_PER_BIT - 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [2:0]      bit_q,   bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            txd_q,   txd_d;
    logic            bit_end;

    // Last clock of the current bit period (START, DATA and STOP only).
    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state, baud counting, shifting and the next line level.
    // txd_d is the level the line takes on the edge that enters the next
    // state/bit, so txd itself is a clean flop output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        fifo_rd_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_en && !fifo_empty) begin
                    state_d = S_FETCH;
                end
            end

            // fifo_data needs one cycle to reflect the current head.
            S_FETCH: begin
                txd_d   = 1'b1;
                state_d = S_LOAD;
            end

            // Capture the head and pop it in the same cycle.
            S_LOAD: begin
                shreg_d    = fifo_data[7:0];
                fifo_rd_en = 1'b1;
                cnt_d      = '0;
                txd_d      = 1'b0;
                state_d    = S_START;
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    txd_d   = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            // LSB first; the shift register drops one bit per bit boundary.
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: two instances (CLK_PER_BIT 4 and 2), each fed by a
// behavioural model of the BRAM FIFO with registered read data and a lagging
// empty flag, plus a UART line decoder per instance.
module tb_uart_tx_drain;

    localparam int CPB_A = 4;
    localparam int CPB_B = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_en_a = 1'b0, tx_en_b = 1'b0;
    logic       push_a = 1'b0, push_b = 1'b0;
    logic [7:0] pdata_a = 8'h00, pdata_b = 8'h00;
    logic       rd_a, txd_a, busy_a, rd_b, txd_b, busy_b;

    logic       fpush [2];
    logic [7:0] fpdata [2];
    logic       frd [2];
    logic       ftxd [2];
    logic       fbusy [2];

    assign fpush[0] = push_a;   assign fpush[1] = push_b;
    assign fpdata[0] = pdata_a; assign fpdata[1] = pdata_b;
    assign frd[0] = rd_a;       assign frd[1] = rd_b;
    assign ftxd[0] = txd_a;     assign ftxd[1] = txd_b;
    assign fbusy[0] = busy_a;   assign fbusy[1] = busy_b;

    // FIFO model state
    logic [7:0] fmem [2][16];
    int         fwp [2] = '{0, 0};
    int         frp [2] = '{0, 0};
    int         fcnt [2] = '{0, 0};
    int         ovf [2] = '{0, 0};
    int         unf [2] = '{0, 0};
    logic       fempty [2] = '{1'b1, 1'b1};
    logic [7:0] fdata [2] = '{8'h00, 8'h00};

    // Monitor / counters
    int         cyc = 0;
    int         rdc [2] = '{0, 0};
    int         bsy [2] = '{0, 0};
    int         mst [2] = '{0, 0};
    int         moff [2] = '{0, 0};
    logic [7:0] mbyte [2] = '{8'h00, 8'h00};
    int         ferr [2] = '{0, 0};
    int         rxn [2] = '{0, 0};
    logic [7:0] rxb [2][64];
    int         sts [2][64];

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_drain #(.CLK_PER_BIT(CPB_A), .DATAW(8)) dut_a (
        .clk(clk), .rstn(rstn), .tx_en(tx_en_a), .fifo_empty(fempty[0]),
        .fifo_data(fdata[0]), .fifo_rd_en(rd_a), .txd(txd_a), .busy(busy_a)
    );

    uart_tx_drain #(.CLK_PER_BIT(CPB_B), .DATAW(8)) dut_b (
        .clk(clk), .rstn(rstn), .tx_en(tx_en_b), .fifo_empty(fempty[1]),
        .fifo_data(fdata[1]), .fifo_rd_en(rd_b), .txd(txd_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    function automatic int cpb_of(input int m);
        return (m == 0) ? CPB_A : CPB_B;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: read data registered from the head, empty flag one cycle late
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (fpush[m] && fcnt[m] < 16) begin
                fmem[m][fwp[m]] <= fpdata[m];
                fwp[m] <= (fwp[m] + 1) % 16;
            end
            if (fpush[m] && fcnt[m] >= 16) ovf[m] <= ovf[m] + 1;
            if (frd[m] && fcnt[m] > 0) frp[m] <= (frp[m] + 1) % 16;
            if (frd[m] && fcnt[m] == 0) unf[m] <= unf[m] + 1;
            fcnt[m] <= fcnt[m] + ((fpush[m] && fcnt[m] < 16) ? 1 : 0)
                               - ((frd[m] && fcnt[m] > 0) ? 1 : 0);
            fdata[m]  <= fmem[m][frp[m]];
            fempty[m] <= (fcnt[m] == 0);
        end
    end

    // Pop and busy cycle counters
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (frd[m] === 1'b1) rdc[m] <= rdc[m] + 1;
            if (fbusy[m] === 1'b1) bsy[m] <= bsy[m] + 1;
        end
    end

    // UART decoders: sample mid-bit, record byte and start cycle of each frame
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rstn) begin
                mst[m] <= 0;
            end else if (mst[m] == 0) begin
                if (ftxd[m] === 1'b0) begin
                    mst[m]  <= 1;
                    moff[m] <= 1;
                    sts[m][rxn[m] % 64] <= cyc;
                end
            end else begin
                moff[m] <= moff[m] + 1;
                if (moff[m] % cpb_of(m) == cpb_of(m) / 2) begin
                    if (moff[m] / cpb_of(m) == 0) begin
                        if (ftxd[m] !== 1'b0) ferr[m] <= ferr[m] + 1;
                    end else if (moff[m] / cpb_of(m) <= 8) begin
                        mbyte[m][moff[m] / cpb_of(m) - 1] <= ftxd[m];
                    end else begin
                        if (ftxd[m] !== 1'b1) ferr[m] <= ferr[m] + 1;
                        rxb[m][rxn[m] % 64] <= mbyte[m];
                        rxn[m] <= rxn[m] + 1;
                        mst[m] <= 0;
                    end
                end
            end
        end
    end

    task automatic wait_start_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (txd_a === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_rx(input int m, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rxn[m] >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int m, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (fbusy[m] === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        if (txd_a !== 1'b1) begin $display("FAIL reset_txd_a: got %b want 1", txd_a); n_err++; end
        n_cmp++;
        if (busy_a !== 1'b0) begin $display("FAIL reset_busy_a: got %b want 0", busy_a); n_err++; end
        n_cmp++;
        if (rd_a !== 1'b0) begin $display("FAIL reset_rd_a: got %b want 0", rd_a); n_err++; end
        n_cmp++;
        if (txd_b !== 1'b1) begin $display("FAIL reset_txd_b: got %b want 1", txd_b); n_err++; end
        n_cmp++;
        if (busy_b !== 1'b0) begin $display("FAIL reset_busy_b: got %b want 0", busy_b); n_err++; end
        n_cmp++;
    endtask

    task automatic test_single();
        int   rd0 = rdc[0];
        int   b0 = bsy[0];
        int   r0 = rxn[0];
        int   fe0 = ferr[0];
        bit   ok;
        logic bad [10];
        // 0xA5 framed: start, 1,0,1,0,0,1,0,1 (LSB first), stop
        logic exp_line [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tx_en_a = 1'b1;
        push_a = 1'b1; pdata_a = 8'hA5;
        @(negedge clk);
        push_a = 1'b0;
        wait_start_a(ok);
        if (!ok) begin $display("FAIL single_start: no start bit within 300 cycles, want one"); n_err++; end
        n_cmp++;
        for (int b = 0; b < 10; b++) bad[b] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (txd_a !== exp_line[i / 4]) bad[i / 4] = 1'b1;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            if (bad[b]) begin
                $display("FAIL single_line_bit%0d: txd left %b during its 4 cycles", b, exp_line[b]);
                n_err++;
            end
            n_cmp++;
        end
        wait_idle(0, 50, ok);
        if (!ok) begin $display("FAIL single_idle: busy stuck high, want 0"); n_err++; end
        n_cmp++;
        repeat (5) @(negedge clk);
        if (rdc[0] - rd0 != 1) begin $display("FAIL single_rd_pulses: got %0d want 1", rdc[0] - rd0); n_err++; end
        n_cmp++;
        // FETCH + LOAD + ten bit times of 4 cycles
        if (bsy[0] - b0 != 42) begin $display("FAIL single_busy_cycles: got %0d want 42", bsy[0] - b0); n_err++; end
        n_cmp++;
        if (fcnt[0] != 0) begin $display("FAIL single_fifo_left: got %0d want 0", fcnt[0]); n_err++; end
        n_cmp++;
        if (rxn[0] - r0 != 1 || rxb[0][r0] !== 8'hA5) begin
            $display("FAIL single_decode: got n=%0d byte=%h want n=1 byte=a5", rxn[0] - r0, rxb[0][r0]);
            n_err++;
        end
        n_cmp++;
        if (ferr[0] != fe0) begin $display("FAIL single_framing: got %0d errors want 0", ferr[0] - fe0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int         rd0 = rdc[0];
        int         r0 = rxn[0];
        bit         ok;
        logic [7:0] exp_b [3] = '{8'h00, 8'hFF, 8'h3C};
        push_a = 1'b1; pdata_a = 8'h00;
        @(negedge clk);
        pdata_a = 8'hFF;
        @(negedge clk);
        pdata_a = 8'h3C;
        @(negedge clk);
        push_a = 1'b0;
        wait_rx(0, r0 + 3, 3 * 43 + 100, ok);
        if (!ok) begin $display("FAIL b2b_frames: got %0d frames want 3", rxn[0] - r0); n_err++; end
        n_cmp++;
        wait_idle(0, 50, ok);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rxb[0][r0 + i] !== exp_b[i]) begin
                $display("FAIL b2b_byte%0d: got %h want %h", i, rxb[0][r0 + i], exp_b[i]);
                n_err++;
            end
            n_cmp++;
        end
        for (int i = 1; i < 3; i++) begin
            if (sts[0][r0 + i] - sts[0][r0 + i - 1] != 43) begin
                $display("FAIL b2b_period%0d: got %0d want 43", i, sts[0][r0 + i] - sts[0][r0 + i - 1]);
                n_err++;
            end
            n_cmp++;
        end
        if (rdc[0] - rd0 != 3) begin $display("FAIL b2b_rd_pulses: got %0d want 3", rdc[0] - rd0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_empty();
        int rd0 = rdc[0];
        int n_txd = 0;
        int n_busy = 0;
        tx_en_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) n_txd++;
            if (busy_a !== 1'b0) n_busy++;
        end
        if (n_txd != 0) begin $display("FAIL empty_txd: got %0d low cycles want 0", n_txd); n_err++; end
        n_cmp++;
        if (n_busy != 0) begin $display("FAIL empty_busy: got %0d busy cycles want 0", n_busy); n_err++; end
        n_cmp++;
        if (rdc[0] != rd0) begin $display("FAIL empty_rd: got %0d pulses want 0", rdc[0] - rd0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_tx_en_gate();
        int rd0 = rdc[0];
        int b0 = bsy[0];
        int r0 = rxn[0];
        int fe0 = ferr[0];
        bit ok;
        tx_en_a = 1'b1;
        push_a = 1'b1; pdata_a = 8'h81;
        @(negedge clk);
        pdata_a = 8'h42;
        @(negedge clk);
        push_a = 1'b0;
        wait_start_a(ok);
        tx_en_a = 1'b0;
        if (!ok) begin $display("FAIL gate_start: no start bit, want one"); n_err++; end
        n_cmp++;
        wait_rx(0, r0 + 1, 100, ok);
        repeat (100) @(negedge clk);
        if (rxn[0] - r0 != 1 || rxb[0][r0] !== 8'h81) begin
            $display("FAIL gate_first: got n=%0d byte=%h want n=1 byte=81", rxn[0] - r0, rxb[0][r0]);
            n_err++;
        end
        n_cmp++;
        if (bsy[0] - b0 != 42) begin $display("FAIL gate_busy_cycles: got %0d want 42", bsy[0] - b0); n_err++; end
        n_cmp++;
        if (fcnt[0] != 1) begin $display("FAIL gate_fifo_held: got %0d want 1", fcnt[0]); n_err++; end
        n_cmp++;
        if (rdc[0] - rd0 != 1) begin $display("FAIL gate_rd_held: got %0d want 1", rdc[0] - rd0); n_err++; end
        n_cmp++;
        tx_en_a = 1'b1;
        wait_rx(0, r0 + 2, 150, ok);
        wait_idle(0, 50, ok);
        repeat (5) @(negedge clk);
        if (rxn[0] - r0 != 2 || rxb[0][r0 + 1] !== 8'h42) begin
            $display("FAIL gate_second: got n=%0d byte=%h want n=2 byte=42", rxn[0] - r0, rxb[0][r0 + 1]);
            n_err++;
        end
        n_cmp++;
        if (rdc[0] - rd0 != 2 || fcnt[0] != 0) begin
            $display("FAIL gate_drained: got pulses=%0d fifo=%0d want 2 and 0", rdc[0] - rd0, fcnt[0]);
            n_err++;
        end
        n_cmp++;
        if (ferr[0] != fe0) begin $display("FAIL gate_framing: got %0d errors want 0", ferr[0] - fe0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid_frame();
        int rd0 = rdc[0];
        int r0 = rxn[0];
        int n_bad = 0;
        bit ok;
        tx_en_a = 1'b1;
        push_a = 1'b1; pdata_a = 8'h55;
        @(negedge clk);
        push_a = 1'b0;
        wait_start_a(ok);
        if (!ok) begin $display("FAIL rstmid_start: no start bit, want one"); n_err++; end
        n_cmp++;
        // offsets 16..19 after the start edge are data bit 3 (0 for 0x55)
        repeat (17) @(negedge clk);
        if (txd_a !== 1'b0) begin $display("FAIL rstmid_bit3: got %b want 0", txd_a); n_err++; end
        n_cmp++;
        rstn = 1'b0;
        #1;
        if (txd_a !== 1'b1) begin $display("FAIL rstmid_txd: got %b want 1", txd_a); n_err++; end
        n_cmp++;
        if (busy_a !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", busy_a); n_err++; end
        n_cmp++;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0) n_bad++;
        end
        if (n_bad != 0) begin $display("FAIL rstmid_idle: got %0d non-idle cycles want 0", n_bad); n_err++; end
        n_cmp++;
        if (rdc[0] - rd0 != 1) begin $display("FAIL rstmid_rd: got %0d pulses want 1", rdc[0] - rd0); n_err++; end
        n_cmp++;
        if (rxn[0] != r0) begin $display("FAIL rstmid_partial: got %0d frames want 0", rxn[0] - r0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_burst_fast();
        int rd0 = rdc[1];
        int r0 = rxn[1];
        int fe0 = ferr[1];
        int n_per = 0;
        bit ok;
        tx_en_b = 1'b0;
        push_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pdata_b = 8'(i);
            @(negedge clk);
        end
        push_b = 1'b0;
        repeat (3) @(negedge clk);
        if (fcnt[1] != 16 || ovf[1] != 0) begin
            $display("FAIL burst_full: got count=%0d ovf=%0d want 16 and 0", fcnt[1], ovf[1]);
            n_err++;
        end
        n_cmp++;
        if (rdc[1] != rd0) begin $display("FAIL burst_no_pop_disabled: got %0d want 0", rdc[1] - rd0); n_err++; end
        n_cmp++;
        tx_en_b = 1'b1;
        wait_rx(1, r0 + 16, 16 * 23 + 100, ok);
        if (!ok) begin $display("FAIL burst_frames: got %0d want 16", rxn[1] - r0); n_err++; end
        n_cmp++;
        wait_idle(1, 50, ok);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (rxb[1][r0 + i] !== 8'(i)) begin
                $display("FAIL burst_byte%0d: got %h want %h", i, rxb[1][r0 + i], 8'(i));
                n_err++;
            end
            n_cmp++;
        end
        for (int i = 1; i < 16; i++)
            if (sts[1][r0 + i] - sts[1][r0 + i - 1] != 23) n_per++;
        if (n_per != 0) begin $display("FAIL burst_period: got %0d gaps off 23 want 0", n_per); n_err++; end
        n_cmp++;
        if (rdc[1] - rd0 != 16 || unf[1] != 0) begin
            $display("FAIL burst_pops: got pulses=%0d underflow=%0d want 16 and 0", rdc[1] - rd0, unf[1]);
            n_err++;
        end
        n_cmp++;
        if (fcnt[1] != 0 || ferr[1] != fe0) begin
            $display("FAIL burst_end: got fifo=%0d framing=%0d want 0 and 0", fcnt[1], ferr[1] - fe0);
            n_err++;
        end
        n_cmp++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        test_single();
        test_back_to_back();
        test_empty();
        test_tx_en_gate();
        test_reset_mid_frame();
        test_burst_fast();
        if (unf[0] != 0) begin $display("FAIL underflow_a: got %0d want 0", unf[0]); n_err++; end
        n_cmp++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: run exceeded 1 ms, want completion");
        $fatal(1, "timeout");
    end

endmodule
